alu_flag_wb: RTL and testbench
==============================

# alu_flag_wb

Writeback and flag stage directly downstream of the arithmetic ALU unit. It accepts each 8-bit ALU result with its carry and overflow outputs, and updates the architectural C, Z and V flags. Flag C is fed back as the ALU `cin` for addc/subc. The result is held in a one-entry buffer and drained to the register-file write port through a valid/ready handshake.

## Interface
Parameters:
- DATA_W, 8, result/write-data width (must match ALU width)
- RA_W, 3, register address width; register 0 is hard-wired zero

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous, active-low
- res_valid  in  1  ALU result valid this cycle
- res_ready  out  1  stage can accept a result this cycle
- alu_out  in  DATA_W  ALU result
- alu_cout  in  1  ALU carry out
- alu_vout  in  1  ALU overflow out
- rd  in  RA_W  destination register of the result
- wr_en  in  1  1 = write result to rd; 0 = flags-only op (compare)
- upd_flags  in  1  1 = update C/Z/V from this result
- flag_ld  in  1  load flags from flag_ld_val (reti restore)
- flag_ld_val  in  3  {C,Z,V} restore value
- flag_c  out  1  carry flag; drives ALU cin
- flag_z  out  1  zero flag
- flag_v  out  1  overflow flag
- rf_we  out  1  register-file write request (valid)
- rf_waddr  out  RA_W  write address
- rf_wdata  out  DATA_W  write data
- rf_ready  in  1  register file accepts the write this cycle

## Operation
- Accept: `acc = res_valid & res_ready`. Inputs are sampled only on acc. When res_valid=1 and res_ready=0, the source holds all inputs stable.
- Flags on acc with upd_flags=1:
  - C <= alu_cout
  - Z <= (alu_out == 0)
  - V <= alu_vout
- Flags are unchanged when upd_flags=0 or there is no acc.
- flag_ld=1 loads {C,Z,V} <= flag_ld_val. flag_ld is independent of res_valid and takes priority over a simultaneous acc flag update. The accepted result is still buffered.
- Write buffer FSM, two states:
  - EMPTY: rf_we=0. An acc with wr_en=1 and rd!=0 captures {rd, alu_out} and moves to PEND. Any other acc stays in EMPTY.
  - PEND: rf_we=1, with rf_waddr/rf_wdata from the buffer.
    - rf_ready=1 with no new capturing acc: move to EMPTY.
    - rf_ready=1 with a capturing acc in the same cycle: reload the buffer and stay in PEND (back-to-back).
    - rf_ready=0: hold the buffer and rf_we.
- Writes to register 0 are dropped; their flag effects still apply.
- res_ready = (state==EMPTY) | rf_ready. This is combinational from state and rf_ready, with no path from res_valid.
- Flags-only ops (wr_en=0) are still gated by res_ready, which keeps flag order consistent with write order.
- rf_waddr/rf_wdata are don't-care in EMPTY but held at the last value; they are never X after reset.

## Timing
- Reset (rst_n=0, asynchronous): flag_c=0, flag_z=0, flag_v=0, rf_we=0, rf_waddr=0, rf_wdata=0, state=EMPTY. res_ready=1 throughout reset, because it follows state=EMPTY.
- Flag latency: 1 cycle. Updated flags are visible the cycle after acc, so a dependent addc issued the next cycle sees the new C.
- Write latency: rf_we rises the cycle after acc.
- Throughput: one result per cycle while rf_ready=1.
- Stall: rf_ready=0 in PEND holds rf_we/addr/data stable and forces res_ready=0. Deassertion takes effect combinationally in the same cycle.
- Reset mid-PEND: the pending write is discarded and the flags clear immediately. The first acc after reset release behaves as from EMPTY.

## Test plan
- Reset: rst_n=0 mid-PEND -> outputs zero immediately, res_ready=1; after release, one acc with rd=2, alu_out=0x5A -> rf_we=1, rf_waddr=2, rf_wdata=0x5A next cycle.
- Flags: acc with alu_out=0x00, cout=1, vout=1, upd_flags=1 -> next cycle C=1, Z=1, V=1; then acc with 0x01, cout=0, vout=0, upd_flags=0 -> flags unchanged.
- Back-to-back with rf_ready=1: writes r1=0x11, r2=0x22, r3=0x33 on consecutive cycles -> three rf_we cycles in order, res_ready constantly 1.
- Backpressure: rf_ready=0 for 3 cycles while PEND holds r4=0xAA, res_valid=1 with r5=0xBB -> res_ready=0 and rf_we held with 0xAA for all 3 cycles; on rf_ready=1, r5 is accepted, then 0xBB is written.
- r0 and compare: acc with rd=0, wr_en=1, alu_out=0x00 -> no rf_we, Z=1; acc with wr_en=0, rd=3 -> no rf_we, flags updated.
- flag_ld collision: flag_ld=1, val=3'b010 in the same cycle as acc with upd_flags=1, cout=1 -> flags {C,Z,V}=010, and the accepted result is still written.

Source files
------------

// File: rtl/alu_flag_wb_if.sv
// Bus between the ALU result source, the flag/writeback stage and the
// register-file write port.
//
// Handshakes: a transfer happens on a rising clock edge when valid and ready
// are both 1 (res_valid/res_ready on the result side, rf_we/rf_ready on the
// register-file side). The valid side holds its payload stable until the
// transfer happens. Ready never depends combinationally on valid.
interface alu_flag_wb_if #(
  parameter int DATA_W = 8,
  parameter int RA_W   = 3
);
  logic              res_valid;
  logic              res_ready;
  logic [DATA_W-1:0] alu_out;
  logic              alu_cout;
  logic              alu_vout;
  logic [RA_W-1:0]   rd;
  logic              wr_en;
  logic              upd_flags;
  logic              flag_ld;
  logic [2:0]        flag_ld_val;
  logic              flag_c;
  logic              flag_z;
  logic              flag_v;
  logic              rf_we;
  logic [RA_W-1:0]   rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic              rf_ready;

  // Stage side: consumes ALU results, produces flags and register writes.
  modport slave (
    input  res_valid, alu_out, alu_cout, alu_vout, rd, wr_en, upd_flags,
    input  flag_ld, flag_ld_val, rf_ready,
    output res_ready, flag_c, flag_z, flag_v, rf_we, rf_waddr, rf_wdata
  );

  // Environment side: ALU result source plus register-file write port.
  modport master (
    output res_valid, alu_out, alu_cout, alu_vout, rd, wr_en, upd_flags,
    output flag_ld, flag_ld_val, rf_ready,
    input  res_ready, flag_c, flag_z, flag_v, rf_we, rf_waddr, rf_wdata
  );
endinterface

// File: rtl/alu_flag_wb.sv
// Flag and writeback stage behind the ALU. Keeps the architectural C/Z/V
// flags (C feeds the ALU carry-in) and buffers one result for the register
// file write port. The buffer is a two-state FSM; a new result can be taken
// in the same cycle the buffered one drains, so throughput is one per cycle
// while the register file is ready.
module alu_flag_wb #(
  parameter int DATA_W = 8,
  parameter int RA_W   = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  alu_flag_wb_if.slave  bus,
  output logic          o_dbg_state   // 0 = EMPTY, 1 = PEND
);

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_PEND  = 1'b1
  } state_t;

  state_t            r_state;
  logic              r_rf_we;
  logic [RA_W-1:0]   r_waddr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_c;
  logic              r_z;
  logic              r_v;

  logic w_ready;
  logic w_acc;
  logic w_cap;

  // Ready comes only from state and rf_ready, never from res_valid.
  assign w_ready = (r_state == S_EMPTY) | bus.rf_ready;
  assign w_acc   = bus.res_valid & w_ready;
  // Writes to register 0 are dropped here; their flags still update.
  assign w_cap   = w_acc & bus.wr_en & (bus.rd != '0);

  assign bus.res_ready = w_ready;
  assign bus.rf_we     = r_rf_we;
  assign bus.rf_waddr  = r_waddr;
  assign bus.rf_wdata  = r_wdata;
  assign bus.flag_c    = r_c;
  assign bus.flag_z    = r_z;
  assign bus.flag_v    = r_v;
  assign o_dbg_state   = r_state;

  // Flag register: restore load wins over an update from an accepted result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_c <= 1'b0;
      r_z <= 1'b0;
      r_v <= 1'b0;
    end else if (bus.flag_ld) begin
      {r_c, r_z, r_v} <= bus.flag_ld_val;
    end else if (w_acc && bus.upd_flags) begin
      r_c <= bus.alu_cout;
      r_z <= (bus.alu_out == '0);
      r_v <= bus.alu_vout;
    end
  end

  // Write buffer FSM with registered rf_we/addr/data; addr/data hold their
  // last value when the buffer empties.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_EMPTY;
      r_rf_we <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_cap) begin
            r_waddr <= bus.rd;
            r_wdata <= bus.alu_out;
            r_rf_we <= 1'b1;
            r_state <= S_PEND;
          end
        end
        S_PEND: begin
          if (bus.rf_ready) begin
            if (w_cap) begin
              // Back-to-back: drain and reload in the same cycle.
              r_waddr <= bus.rd;
              r_wdata <= bus.alu_out;
            end else begin
              r_rf_we <= 1'b0;
              r_state <= S_EMPTY;
            end
          end
        end
        default: begin
          r_rf_we <= 1'b0;
          r_state <= S_EMPTY;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_flag_wb.sv
// Bench for alu_flag_wb: directed scenarios followed by random traffic, all
// checked each cycle against a reference model made of a queue of accepted
// writes not yet drained plus the architectural flag triple.
module tb_alu_flag_wb;
  localparam int DATA_W = 8;
  localparam int RA_W   = 3;

  logic clk;
  logic rst_n;
  logic dbg_state;

  alu_flag_wb_if #(.DATA_W(DATA_W), .RA_W(RA_W)) bus ();

  alu_flag_wb #(.DATA_W(DATA_W), .RA_W(RA_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard / model ----------------
  logic [RA_W+DATA_W-1:0] exp_q[$];   // {addr, data} of accepted, undrained writes
  logic [2:0]             exp_flags;  // {C,Z,V}
  logic                   stalled;
  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    exp_flags = 3'b000;
    stalled   = 1'b0;
  endtask

  // Check all outputs against the model mid-cycle, then advance the model and
  // the clock by one edge. Returns at posedge+1.
  task automatic tick();
    logic exp_ready;
    logic acc;
    @(negedge clk);
    exp_ready = (exp_q.size() == 0) || bus.rf_ready;
    chk("res_ready", 32'(bus.res_ready), 32'(exp_ready));
    chk("rf_we", 32'(bus.rf_we), 32'(exp_q.size() != 0));
    chk("dbg_state", 32'(dbg_state), 32'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      chk("rf_waddr", 32'(bus.rf_waddr), 32'(exp_q[0][RA_W+DATA_W-1:DATA_W]));
      chk("rf_wdata", 32'(bus.rf_wdata), 32'(exp_q[0][DATA_W-1:0]));
    end
    chk("flags", 32'({bus.flag_c, bus.flag_z, bus.flag_v}), 32'(exp_flags));
    acc     = bus.res_valid && exp_ready;
    stalled = bus.res_valid && !exp_ready;
    if (exp_q.size() != 0 && bus.rf_ready) void'(exp_q.pop_front());
    if (acc && bus.wr_en && bus.rd != 0) exp_q.push_back({bus.rd, bus.alu_out});
    if (bus.flag_ld) exp_flags = bus.flag_ld_val;
    else if (acc && bus.upd_flags)
      exp_flags = {bus.alu_cout, (bus.alu_out == 0), bus.alu_vout};
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic v, input logic [RA_W-1:0] rd, input logic we,
                       input logic [DATA_W-1:0] d, input logic co, input logic vo,
                       input logic upd);
    bus.res_valid = v;
    bus.rd        = rd;
    bus.wr_en     = we;
    bus.alu_out   = d;
    bus.alu_cout  = co;
    bus.alu_vout  = vo;
    bus.upd_flags = upd;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n           = 1'b0;
    bus.rf_ready    = 1'b1;
    bus.flag_ld     = 1'b0;
    bus.flag_ld_val = 3'b000;
    drive(0, 0, 0, 8'h00, 0, 0, 0);
    model_reset();
    #2;
    chk("reset_rf_we", 32'(bus.rf_we), 0);
    chk("reset_res_ready", 32'(bus.res_ready), 1);
    chk("reset_flags", 32'({bus.flag_c, bus.flag_z, bus.flag_v}), 0);
    #10 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Reset in the middle of a pending write.
    bus.rf_ready = 1'b0;
    drive(1, 3'd1, 1, 8'h77, 1, 1, 1);
    tick();
    drive(0, 0, 0, 8'h00, 0, 0, 0);
    chk("pend_before_reset", 32'(bus.rf_we), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_rf_we", 32'(bus.rf_we), 0);
    chk("rst_mid_waddr", 32'(bus.rf_waddr), 0);
    chk("rst_mid_wdata", 32'(bus.rf_wdata), 0);
    chk("rst_mid_flags", 32'({bus.flag_c, bus.flag_z, bus.flag_v}), 0);
    chk("rst_mid_res_ready", 32'(bus.res_ready), 1);
    model_reset();
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    bus.rf_ready = 1'b1;
    drive(1, 3'd2, 1, 8'h5A, 0, 0, 0);
    tick();
    drive(0, 0, 0, 8'h00, 0, 0, 0);
    chk("post_rst_rf_we", 32'(bus.rf_we), 1);
    chk("post_rst_waddr", 32'(bus.rf_waddr), 2);
    chk("post_rst_wdata", 32'(bus.rf_wdata), 32'h5A);
    tick();

    // Flag update, then a non-updating result.
    drive(1, 3'd0, 0, 8'h00, 1, 1, 1);
    tick();
    chk("flags_set", 32'({bus.flag_c, bus.flag_z, bus.flag_v}), 32'b111);
    drive(1, 3'd0, 0, 8'h01, 0, 0, 0);
    tick();
    chk("flags_hold", 32'({bus.flag_c, bus.flag_z, bus.flag_v}), 32'b111);

    // Back-to-back writes with rf_ready high.
    drive(1, 3'd1, 1, 8'h11, 0, 0, 0);
    #1 chk("b2b_ready0", 32'(bus.res_ready), 1);
    tick();
    chk("b2b_w1", 32'({bus.rf_we, bus.rf_waddr, bus.rf_wdata}), 32'({1'b1, 3'd1, 8'h11}));
    drive(1, 3'd2, 1, 8'h22, 0, 0, 0);
    #1 chk("b2b_ready1", 32'(bus.res_ready), 1);
    tick();
    chk("b2b_w2", 32'({bus.rf_we, bus.rf_waddr, bus.rf_wdata}), 32'({1'b1, 3'd2, 8'h22}));
    drive(1, 3'd3, 1, 8'h33, 0, 0, 0);
    #1 chk("b2b_ready2", 32'(bus.res_ready), 1);
    tick();
    chk("b2b_w3", 32'({bus.rf_we, bus.rf_waddr, bus.rf_wdata}), 32'({1'b1, 3'd3, 8'h33}));
    drive(0, 0, 0, 8'h00, 0, 0, 0);
    tick();
    chk("b2b_drained", 32'(bus.rf_we), 0);

    // Backpressure: r4 held three cycles while r5 waits.
    bus.rf_ready = 1'b0;
    drive(1, 3'd4, 1, 8'hAA, 0, 0, 0);
    tick();
    drive(1, 3'd5, 1, 8'hBB, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_ready_low", 32'(bus.res_ready), 0);
      chk("bp_hold", 32'({bus.rf_we, bus.rf_waddr, bus.rf_wdata}), 32'({1'b1, 3'd4, 8'hAA}));
      tick();
    end
    bus.rf_ready = 1'b1;
    #1 chk("bp_release_ready", 32'(bus.res_ready), 1);
    tick();
    drive(0, 0, 0, 8'h00, 0, 0, 0);
    chk("bp_r5", 32'({bus.rf_we, bus.rf_waddr, bus.rf_wdata}), 32'({1'b1, 3'd5, 8'hBB}));
    tick();

    // Register 0 write and compare op.
    drive(1, 3'd0, 1, 8'h00, 0, 0, 1);
    tick();
    chk("r0_no_we", 32'(bus.rf_we), 0);
    chk("r0_flags", 32'({bus.flag_c, bus.flag_z, bus.flag_v}), 32'b010);
    drive(1, 3'd3, 0, 8'h80, 1, 0, 1);
    tick();
    chk("cmp_no_we", 32'(bus.rf_we), 0);
    chk("cmp_flags", 32'({bus.flag_c, bus.flag_z, bus.flag_v}), 32'b100);

    // Flag restore collides with an updating, writing result.
    bus.flag_ld     = 1'b1;
    bus.flag_ld_val = 3'b010;
    drive(1, 3'd6, 1, 8'h3C, 1, 1, 1);
    tick();
    bus.flag_ld = 1'b0;
    drive(0, 0, 0, 8'h00, 0, 0, 0);
    chk("ld_flags", 32'({bus.flag_c, bus.flag_z, bus.flag_v}), 32'b010);
    chk("ld_write", 32'({bus.rf_we, bus.rf_waddr, bus.rf_wdata}), 32'({1'b1, 3'd6, 8'h3C}));
    tick();

    // Random traffic; the source holds its payload while stalled.
    for (int n = 0; n < 400; n++) begin
      if (!stalled) begin
        drive($urandom_range(0, 9) < 7,
              RA_W'($urandom_range(0, 7)),
              $urandom_range(0, 9) < 8,
              ($urandom_range(0, 3) == 0) ? 8'h00 : DATA_W'($urandom_range(0, 255)),
              1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)));
      end
      bus.rf_ready    = $urandom_range(0, 9) < 6;
      bus.flag_ld     = $urandom_range(0, 9) == 0;
      bus.flag_ld_val = 3'($urandom_range(0, 7));
      tick();
    end

    // Drain.
    drive(0, 0, 0, 8'h00, 0, 0, 0);
    bus.flag_ld  = 1'b0;
    bus.rf_ready = 1'b1;
    tick();
    tick();
    chk("final_empty", 32'(bus.rf_we), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
